// File: rtl/md_div_iter_if.sv
// Handshake and result bus between the E-stage multiply/divide unit and the
// iterative divider core.
interface md_div_iter_if;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [5:0]  cyc_left;

    modport master (
        output start, is_signed, dividend, divisor, abort,
        input  busy, done, quo, rem, cyc_left
    );

    modport slave (
        input  start, is_signed, dividend, divisor, abort,
        output busy, done, quo, rem, cyc_left
    );
endinterface

// File: rtl/md_div_iter.sv
// Iterative radix-2 restoring divider for div/divu: 33-edge start-to-done
// latency, quotient to LO, remainder to HI, abortable by CP0.
module md_div_iter (
    input  logic          clk,
    input  logic          reset,
    md_div_iter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;

    logic        busy_r;
    logic        done_r;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [5:0]  cyc_r;

    logic [31:0] acc_r;
    logic [31:0] q_sr_r;
    logic [31:0] b_abs_r;
    logic [31:0] dvd_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic        div0_r;
    logic [4:0]  cnt_r;

    logic        accept_s;
    logic        load_s;
    logic        step_s;
    logic        fix_s;
    logic        busy_s;
    logic [5:0]  cyc_s;
    logic [31:0] a_abs_s;
    logic [31:0] b_abs_s;
    logic [32:0] t_s;

    // The done cycle is still busy, so a new start is only taken once done drops.
    assign accept_s = (state_r == IDLE) && bus.start && !bus.abort && !done_r;

    assign a_abs_s = (bus.is_signed && bus.dividend[31]) ? (32'd0 - bus.dividend) : bus.dividend;
    assign b_abs_s = (bus.is_signed && bus.divisor[31])  ? (32'd0 - bus.divisor)  : bus.divisor;
    assign t_s     = {acc_r, q_sr_r[31]} - {1'b0, b_abs_r};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = ITER;
                end else begin
                    state_s = IDLE;
                end
            end
            ITER: begin
                if (bus.abort) begin
                    state_s = IDLE;
                end else if (cnt_r == 5'd31) begin
                    state_s = FIX;
                end else begin
                    state_s = ITER;
                end
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output/control decode: what the datapath does on the coming edge.
    always_comb begin
        load_s = 1'b0;
        step_s = 1'b0;
        fix_s  = 1'b0;
        busy_s = 1'b0;
        cyc_s  = 6'd0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    load_s = 1'b1;
                    busy_s = 1'b1;
                    cyc_s  = 6'd33;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ITER: begin
                if (!bus.abort) begin
                    step_s = 1'b1;
                    busy_s = 1'b1;
                    cyc_s  = cyc_r - 6'd1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            FIX: begin
                if (!bus.abort) begin
                    fix_s  = 1'b1;
                    busy_s = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            quo_r   <= 32'd0;
            rem_r   <= 32'd0;
            cyc_r   <= 6'd0;
            acc_r   <= 32'd0;
            q_sr_r  <= 32'd0;
            b_abs_r <= 32'd0;
            dvd_r   <= 32'd0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            div0_r  <= 1'b0;
            cnt_r   <= 5'd0;
        end else begin
            busy_r <= busy_s;
            done_r <= fix_s;
            cyc_r  <= cyc_s;
            if (load_s) begin
                acc_r   <= 32'd0;
                q_sr_r  <= a_abs_s;
                b_abs_r <= b_abs_s;
                dvd_r   <= bus.dividend;
                neg_q_r <= bus.is_signed & (bus.dividend[31] ^ bus.divisor[31]);
                neg_r_r <= bus.is_signed & bus.dividend[31];
                div0_r  <= (bus.divisor == 32'd0);
                cnt_r   <= 5'd0;
            end else if (step_s) begin
                // A kept difference is below b_abs, so bit 32 is always zero and
                // the partial remainder fits in 32 bits.
                if (!t_s[32]) begin
                    acc_r <= t_s[31:0];
                end else begin
                    acc_r <= {acc_r[30:0], q_sr_r[31]};
                end
                q_sr_r <= {q_sr_r[30:0], ~t_s[32]};
                cnt_r  <= cnt_r + 5'd1;
            end else if (fix_s) begin
                if (div0_r) begin
                    quo_r <= 32'hFFFF_FFFF;
                    rem_r <= dvd_r;
                end else begin
                    quo_r <= neg_q_r ? (32'd0 - q_sr_r) : q_sr_r;
                    rem_r <= neg_r_r ? (32'd0 - acc_r)  : acc_r;
                end
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.quo      = quo_r;
    assign bus.rem      = rem_r;
    assign bus.cyc_left = cyc_r;

endmodule

// File: tb/tb_md_div_iter.sv
// Self-checking bench for md_div_iter: directed cases plus randomized
// operands checked against an arithmetic reference model.
module tb_md_div_iter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    md_div_iter_if bus ();

    md_div_iter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic with truncating signed division.
    task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Drives a one-cycle start; returns at the negedge after the sampling edge E0.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Counts edges after E0 until done is seen; 99 means it never came.
    task automatic wait_done(output int lat);
        lat = 99;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq;
        logic [31:0] er;
        int lat;
        ref_div(s, a, b, eq, er);
        start_op(s, a, b);
        wait_done(lat);
        check_val({tag, "_lat"}, lat, 32'd33);
        check_val({tag, "_quo"}, bus.quo, eq);
        check_val({tag, "_rem"}, bus.rem, er);
        @(negedge clk);
    endtask

    int          lat;
    int          dones;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd0;
        bus.divisor   = 32'd0;
        bus.abort     = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("rst_done", {31'd0, bus.done}, 32'd0);
        check_val("rst_quo", bus.quo, 32'd0);
        check_val("rst_rem", bus.rem, 32'd0);
        check_val("rst_cyc", {26'd0, bus.cyc_left}, 32'd0);
        reset = 1'b0;

        // divu 100/7 with cycle-by-cycle tracking of busy, done and cyc_left.
        start_op(1'b0, 32'd100, 32'd7);
        check_val("e0_busy", {31'd0, bus.busy}, 32'd1);
        check_val("e0_cyc", {26'd0, bus.cyc_left}, 32'd33);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            check_val($sformatf("cyc_e%0d", k), {26'd0, bus.cyc_left}, 33 - k);
            check_val($sformatf("busy_e%0d", k), {31'd0, bus.busy}, 32'd1);
            check_val($sformatf("done_e%0d", k), {31'd0, bus.done}, (k == 33) ? 32'd1 : 32'd0);
        end
        check_val("u100_7_quo", bus.quo, 32'd14);
        check_val("u100_7_rem", bus.rem, 32'd2);
        // A start during the done cycle must be ignored.
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd9; bus.divisor = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        check_val("e34_busy", {31'd0, bus.busy}, 32'd0);
        check_val("e34_done", {31'd0, bus.done}, 32'd0);
        check_val("e34_cyc", {26'd0, bus.cyc_left}, 32'd0);
        check_val("start_in_done", bus.quo, 32'd14);

        run_check("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        check_val("s_m7_2_q_lit", bus.quo, 32'hFFFF_FFFD);
        check_val("s_m7_2_r_lit", bus.rem, 32'hFFFF_FFFF);
        run_check("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
        check_val("u_m7_2_q_lit", bus.quo, 32'h7FFF_FFFC);
        check_val("u_m7_2_r_lit", bus.rem, 32'd1);
        run_check("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check_val("s_ovf_q_lit", bus.quo, 32'h8000_0000);
        run_check("s_div0", 1'b1, 32'hFFFF_FFFB, 32'd0);
        check_val("s_div0_q_lit", bus.quo, 32'hFFFF_FFFF);
        check_val("s_div0_r_lit", bus.rem, 32'hFFFF_FFFB);

        // Abort mid-operation: results keep the previous 100/7 values.
        run_check("u100_7b", 1'b0, 32'd100, 32'd7);
        start_op(1'b0, 32'd50, 32'd5);
        for (int k = 1; k <= 10; k++) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_val("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_val("abort_cyc", {26'd0, bus.cyc_left}, 32'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check_val("abort_no_done", dones, 32'd0);
        check_val("abort_quo", bus.quo, 32'd14);
        check_val("abort_rem", bus.rem, 32'd2);
        run_check("u50_5", 1'b0, 32'd50, 32'd5);
        check_val("u50_5_q_lit", bus.quo, 32'd10);

        // Start and abort together in IDLE: nothing starts.
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1; bus.dividend = 32'd77; bus.divisor = 32'd7;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        check_val("start_abort_busy", {31'd0, bus.busy}, 32'd0);

        // Start while busy is ignored.
        start_op(1'b0, 32'd1000, 32'd3);
        for (int k = 0; k < 5; k++) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'd64; bus.divisor = 32'd8;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check_val("ign_lat", lat, 32'd33 - 32'd6);
        check_val("ign_quo", bus.quo, 32'd333);
        check_val("ign_rem", bus.rem, 32'd1);
        @(negedge clk);

        // Asynchronous reset between edges mid-operation.
        start_op(1'b0, 32'd12345, 32'd11);
        for (int k = 1; k <= 20; k++) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_val("arst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("arst_quo", bus.quo, 32'd0);
        check_val("arst_rem", bus.rem, 32'd0);
        check_val("arst_cyc", {26'd0, bus.cyc_left}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check_val("arst_no_done", dones, 32'd0);

        // Randomized operands, biased towards small and zero divisors.
        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom_range(1, 0));
            ra = $urandom;
            case ($urandom_range(3, 0))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(15, 1);
                2:       rb = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
                default: rb = $urandom;
            endcase
            run_check($sformatf("rnd%0d", i), rs, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
